imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/riscv_pkg.sv | 16 +
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the instruction-memory loader and the core top.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RELEASE,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory after filling it with NOPs,
// then releases the core from reset. Overflowing the memory is a sticky error.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   READY_LIM = (ADDR_W + 1)'(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              handshake;
  logic              begin_load;

  assign in_ready  = (state_q == LOAD) && (word_count_q < READY_LIM);
  assign handshake = in_valid && in_ready;

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;
    begin_load   = 1'b0;

    case (state_q)
      IDLE:    begin_load = start;
      CLEAR: begin
        // imem_addr_q doubles as the clear pointer: it holds the address being written now.
        if (imem_addr_q == LAST_ADDR) begin
          state_d = LOAD;
        end else begin
          imem_we_d    = 1'b1;
          imem_addr_d  = imem_addr_q + 1'b1;
          imem_wdata_d = NOP_INSTR;
        end
      end
      LOAD: begin
        if (handshake) begin
          word_count_d = word_count_q + 1'b1;
          if (word_count_q < DEPTH_CNT) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = in_data;
            if (in_last) state_d = RELEASE;
          end else begin
            error_d = 1'b1;
            state_d = ERROR;
          end
        end
      end
      RELEASE: state_d = RUN;
      RUN:     begin_load = start;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    if (begin_load) begin
      state_d      = CLEAR;
      word_count_d = '0;
      imem_we_d    = 1'b1;
      imem_addr_d  = '0;
      imem_wdata_d = NOP_INSTR;
    end

    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by an independent monitor; a bench-side memory image is checked after each load.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  wr_t         sb[$];
  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] exp_img [DEPTH];
  logic [31:0] prog_a[$];
  logic [31:0] prog_b[$];
  logic [31:0] prog_one[$];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we) tb_mem[imem_addr] <= imem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && imem_we) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    for (int i = 0; i < DEPTH; i++) sb.push_back('{addr: ADDR_W'(i), data: NOP});
    n_acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic wait_load(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cycles++;
      if (cycles > DEPTH + 20) begin
        check("wait_load_timeout", 32'(cycles), 32'(DEPTH));
        break;
      end
    end
    tick();
  endtask

  // Present one word; queue its expected write if it fits in memory.
  task automatic send(input logic [31:0] d, input logic last);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (n_acc < DEPTH) sb.push_back('{addr: ADDR_W'(n_acc), data: d});
        n_acc++;
        tick();
        break;
      end
      budget++;
      if (budget > 20) begin
        check("send_timeout", 32'(budget), 32'd0);
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic load_prog(input logic [31:0] words[$], input bit gap);
    for (int i = 0; i < words.size(); i++) begin
      send(words[i], i == words.size() - 1);
      if (gap && i != words.size() - 1) begin
        start = (i == 5);
        tick();
        start = 1'b0;
      end
    end
  endtask

  task automatic release_checks(input int n);
    @(negedge clk);
    check("release_cpu_reset", 32'(cpu_reset), 32'd1);
    check("release_done", 32'(done), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("run_done", 32'(done), 32'd1);
    check("run_word_count", 32'(word_count), 32'(n));
    tick();
  endtask

  task automatic fill_exp(input logic [31:0] words[$]);
    for (int i = 0; i < DEPTH; i++) exp_img[i] = (i < words.size()) ? words[i] : NOP;
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (tb_mem[i] !== exp_img[i]) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, tb_mem[i], exp_img[i]);
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int cycles;
    int budget;
    prog_a = '{32'h00500513, 32'h00300593, 32'h00B50633, 32'h40B606B3,
               32'h00A02023, 32'h00002703, 32'h000017B7, 32'h00000817,
               32'h00000463, 32'h00100513, 32'h0080006F, 32'h00200513,
               32'h000508B3, 32'h40050933, 32'h01102223, 32'h0000006F};
    prog_b   = '{32'h00700593, 32'h00B58633, 32'h00C02023, 32'h0000006F};
    prog_one = '{32'h00500513};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    tick();
    reset = 1'b0;
    tick();

    // Full program load; CLEAR must last exactly DEPTH cycles.
    do_start();
    wait_load(cycles);
    check("clear_cycles", 32'(cycles), 32'(DEPTH));
    load_prog(prog_a, 1'b0);
    release_checks(16);
    fill_exp(prog_a);
    check_image("img_a");

    // Valid without ready in RUN: no write, no count change.
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("run_idle_word_count", 32'(word_count), 32'd16);
    check("run_idle_done", 32'(done), 32'd1);
    tick();

    // Reload with gaps between words and a start pulse mid-LOAD that must be ignored.
    do_start();
    wait_load(cycles);
    load_prog(prog_a, 1'b1);
    release_checks(16);
    check_image("img_a_gap");

    // Program B overwrites A; tail must be NOP again.
    do_start();
    wait_load(cycles);
    load_prog(prog_b, 1'b0);
    release_checks(4);
    fill_exp(prog_b);
    check_image("img_b");

    // Single-word program.
    do_start();
    wait_load(cycles);
    load_prog(prog_one, 1'b0);
    release_checks(1);
    fill_exp(prog_one);
    check_image("img_one");

    // Reset during CLEAR at address 20, then a clean load.
    do_start();
    budget = 0;
    while (!(imem_we && imem_addr == 6'd20) && budget < 100) begin
      tick();
      budget++;
    end
    check("reach_clear_20", 32'(imem_addr), 32'd20);
    reset = 1'b1;
    tick();
    sb.delete();
    @(negedge clk);
    reset_checks("mid_clear");
    tick();
    reset = 1'b0;
    tick();
    do_start();
    wait_load(cycles);
    load_prog(prog_a, 1'b0);
    release_checks(16);
    fill_exp(prog_a);
    check_image("img_after_rst");

    // Overflow: 65 words, no in_last.
    do_start();
    wait_load(cycles);
    for (int i = 0; i <= DEPTH; i++) begin
      send(32'hA000_0000 + 32'(i), 1'b0);
      exp_img[i % DEPTH] = 32'hA000_0000 + 32'(i % DEPTH);
    end
    @(negedge clk);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_word_count", 32'(word_count), 32'(DEPTH + 1));
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);
    check("err_cpu_reset", 32'(cpu_reset), 32'd1);
    check("err_done", 32'(done), 32'd0);
    check("err_imem_we", 32'(imem_we), 32'd0);
    check_image("img_ovf");

    reset = 1'b1;
    tick();
    @(negedge clk);
    reset_checks("final");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
